// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the data-memory access unit and its load
//   extension helper.
//   - req_size_e  : encoding of the REQ_SIZE field
//   - mau_state_e : sequencer states
//   - BYTE_W      : width of one memory byte lane
package mem_access_unit_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } req_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_RESP = 2'b11
    } mau_state_e;

endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend
//   Combinational size/sign extension of captured load data.
//   Ports:
//     size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//     is_signed in  1   sign-extend byte/half results
//     word_data in  32  captured full word (word loads)
//     hi_byte   in  8   captured high byte (half loads, first byte)
//     lo_byte   in  8   captured low byte (byte loads, half second byte)
//     rdata     out 32  extended result
module mem_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [31:0]       word_data,
    input  logic [BYTE_W-1:0] hi_byte,
    input  logic [BYTE_W-1:0] lo_byte,
    output logic [31:0]       rdata
);

    logic is_word;
    logic is_half;
    logic fill_byte;
    logic fill_half;

    assign is_word   = (size == SZ_WORD);
    assign is_half   = (size == SZ_HALF);
    // A half is {hi, lo}, so its sign bit lives in the high byte.
    assign fill_byte = is_signed & lo_byte[BYTE_W-1];
    assign fill_half = is_signed & hi_byte[BYTE_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            if (gi < BYTE_W) begin : g_lo
                assign rdata[gi] = is_word ? word_data[gi] : lo_byte[gi];
            end else if (gi < 2 * BYTE_W) begin : g_hi
                assign rdata[gi] = is_word ? word_data[gi]
                                 : (is_half ? hi_byte[gi - BYTE_W] : fill_byte);
            end else begin : g_ext
                assign rdata[gi] = is_word ? word_data[gi]
                                 : (is_half ? fill_half : fill_byte);
            end
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the data-memory interface. Accepts one load/store at a
//   time, validates size/alignment/range, drives the memory A/L/WE/WD port
//   (halfwords as two byte accesses, high byte first) and returns a one-cycle
//   response with extended load data.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid/req_ready   request handshake
//     req_we, req_size, req_signed, req_addr, req_wdata   request fields
//     rsp_valid, rsp_rdata, rsp_err                        response
//     a, l, we, wd          memory address, byte-lane select, write enable, data
//     rd                    memory read data (combinational from a/l)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int AL = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] a,
    output logic        l,
    output logic        we,
    output logic [31:0] wd,
    input  logic [31:0] rd
);

    mau_state_e        state_reg, state_next;
    logic              op_we_reg;
    logic [1:0]        op_size_reg;
    logic              op_signed_reg;
    logic [31:0]       op_addr_reg;
    logic [31:0]       op_wdata_reg;
    logic              err_reg;
    logic [31:0]       rd_word_reg;
    logic [BYTE_W-1:0] hi_byte_reg;
    logic [BYTE_W-1:0] lo_byte_reg;

    logic              accept;
    logic              req_err;
    logic              addr_oor;
    logic [31:0]       ext_rdata;

    // Any address bit at or above AL puts the access outside the memory.
    assign addr_oor = |(req_addr >> AL);

    assign req_err = (req_size == SZ_ILLEGAL)
                   | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | addr_oor;

    assign accept = (state_reg == ST_IDLE) & req_valid;

    // State register and request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_we_reg     <= 1'b0;
            op_size_reg   <= 2'b00;
            op_signed_reg <= 1'b0;
            op_addr_reg   <= '0;
            op_wdata_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_we_reg     <= req_we;
                op_size_reg   <= req_size;
                op_signed_reg <= req_signed;
                op_addr_reg   <= req_addr;
                op_wdata_reg  <= req_wdata;
                err_reg       <= req_err;
            end
        end
    end

    // Load data capture at the end of each access cycle. Half loads put the
    // first (lower-address, more significant) byte in hi_byte_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_reg <= '0;
            hi_byte_reg <= '0;
            lo_byte_reg <= '0;
        end else if (!op_we_reg) begin
            if (state_reg == ST_ACC0) begin
                if (op_size_reg == SZ_WORD) begin
                    rd_word_reg <= rd;
                end else if (op_size_reg == SZ_HALF) begin
                    hi_byte_reg <= rd[BYTE_W-1:0];
                end else begin
                    lo_byte_reg <= rd[BYTE_W-1:0];
                end
            end else if (state_reg == ST_ACC1) begin
                lo_byte_reg <= rd[BYTE_W-1:0];
            end
        end
    end

    mem_load_extend u_load_extend (
        .size      (op_size_reg),
        .is_signed (op_signed_reg),
        .word_data (rd_word_reg),
        .hi_byte   (hi_byte_reg),
        .lo_byte   (lo_byte_reg),
        .rdata     (ext_rdata)
    );

    // Next-state and outputs. Memory-port outputs are pure decodes of the
    // state register, so an asynchronous reset drops WE immediately.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        a          = '0;
        l          = 1'b0;
        we         = 1'b0;
        wd         = '0;

        unique case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_err ? ST_RESP : ST_ACC0;
                end
            end
            ST_ACC0: begin
                a  = op_addr_reg;
                l  = (op_size_reg != SZ_WORD);
                we = op_we_reg;
                if (op_we_reg) begin
                    if (op_size_reg == SZ_WORD) begin
                        wd = op_wdata_reg;
                    end else if (op_size_reg == SZ_HALF) begin
                        wd = {24'b0, op_wdata_reg[15:8]};
                    end else begin
                        wd = {24'b0, op_wdata_reg[7:0]};
                    end
                end
                state_next = (op_size_reg == SZ_HALF) ? ST_ACC1 : ST_RESP;
            end
            ST_ACC1: begin
                a  = op_addr_reg + 32'd1;
                l  = 1'b1;
                we = op_we_reg;
                if (op_we_reg) begin
                    wd = {24'b0, op_wdata_reg[7:0]};
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_reg;
                if (!err_reg && !op_we_reg) begin
                    rsp_rdata = ext_rdata;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
